// File: rtl/frame_queue_pkg.sv
// Shared types and sizing for the multi-channel frame queue.
// Holds the arbiter state encoding and the fixed queue and counter widths.
package frame_queue_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} arb_state_t;

    localparam int DEPTH_DFLT = 2048;
    localparam int PTR_W      = $clog2(DEPTH_DFLT);
    localparam int LENQ_DEPTH = 16;
    localparam int LENQ_AW    = $clog2(LENQ_DEPTH);
    localparam int CNT_W      = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/frame_queue_chan.sv
// One channel of the frame queue: byte store, speculative write with commit/drop,
// length queue of committed frames, fill-level pause with hysteresis, frame counters.
module frame_queue_chan
    import frame_queue_pkg::*;
#(
    parameter int DEPTH    = 2048,
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 16,
    parameter int AF_LEVEL = DEPTH - 256,
    parameter int AF_HYST  = 128,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_err,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W:0]   rd_word,
    input  logic              rd_adv,
    input  logic              pop,
    output logic              has_frame,
    output logic [LEN_W-1:0]  head_len,
    output logic [AW-1:0]     head_ptr,
    output logic              pause_req,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  frm_cnt
);

    localparam logic [AW-1:0]        ONE    = AW'(1);
    localparam logic [LENQ_AW:0]     LQ_ONE = (LENQ_AW+1)'(1);
    localparam logic [AW:0]          AF_HI  = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]          AF_LO  = (AW+1)'(AF_LEVEL - AF_HYST);

    logic [DATA_W:0]   mem [DEPTH];
    logic [LEN_W-1:0]  lenq [LENQ_DEPTH];
    logic [AW-1:0]     wr_ptr, commit_ptr, rd_ptr, used;
    logic [LEN_W-1:0]  len;
    logic [LENQ_AW:0]  lq_wp, lq_rp;
    logic              discard, full, lq_full, wr_en, commit;

    assign used    = wr_ptr - rd_ptr;
    assign full    = (wr_ptr + ONE) == rd_ptr;
    assign lq_full = (lq_wp[LENQ_AW] != lq_rp[LENQ_AW]) &&
                     (lq_wp[LENQ_AW-1:0] == lq_rp[LENQ_AW-1:0]);
    assign wr_en   = in_valid && !discard && !full;
    assign commit  = wr_en && in_last && !in_err && !lq_full;

    assign has_frame = lq_wp != lq_rp;
    assign head_len  = lenq[lq_rp[LENQ_AW-1:0]];
    assign head_ptr  = rd_ptr;
    assign rd_word   = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_last, in_data};
        if (commit) lenq[lq_wp[LENQ_AW-1:0]] <= len + LEN_W'(1);
    end

    // Any in_last that does not commit (error, overflow earlier or now, queue full) is one drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            len        <= '0;
            discard    <= 1'b0;
            lq_wp      <= '0;
            frm_cnt    <= '0;
            drop_cnt   <= '0;
        end else if (in_valid) begin
            if (in_last) begin
                len     <= '0;
                discard <= 1'b0;
                if (commit) begin
                    wr_ptr     <= wr_ptr + ONE;
                    commit_ptr <= wr_ptr + ONE;
                    lq_wp      <= lq_wp + LQ_ONE;
                    frm_cnt    <= frm_cnt + CNT_W'(1);
                end else begin
                    wr_ptr   <= commit_ptr;
                    drop_cnt <= sat_inc(drop_cnt);
                end
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
                len    <= len + LEN_W'(1);
            end else begin
                discard <= 1'b1;
                wr_ptr  <= commit_ptr;
                len     <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            lq_rp  <= '0;
        end else begin
            if (rd_adv) rd_ptr <= rd_ptr + ONE;
            if (pop) lq_rp <= lq_rp + LQ_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pause_req <= 1'b0;
        else if ({1'b0, used} >= AF_HI) pause_req <= 1'b1;
        else if ({1'b0, used} < AF_LO) pause_req <= 1'b0;
    end

endmodule

// File: rtl/frame_queue_mux.sv
// N-channel store-and-forward frame queue with a round-robin whole-frame arbiter
// driving one valid/ready byte stream.
module frame_queue_mux
    import frame_queue_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = DEPTH_DFLT,
    parameter int LEN_W    = 16,
    parameter int AF_LEVEL = DEPTH - 256,
    parameter int AF_HYST  = 128,
    localparam int AW      = $clog2(DEPTH),
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    input  logic [N_CH-1:0]          in_err,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_chan,
    output logic [LEN_W-1:0]         out_len,
    input  logic                     out_ready,
    output logic [N_CH-1:0]          pause_req,
    output logic [N_CH*CNT_W-1:0]    drop_cnt,
    output logic [N_CH*CNT_W-1:0]    frm_cnt
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [N_CH-1:0]             has_frame, rd_adv, pop;
    logic [N_CH-1:0][DATA_W:0]   rd_word;
    logic [N_CH-1:0][LEN_W-1:0]  head_len;
    logic [N_CH-1:0][AW-1:0]     head_ptr;

    arb_state_t          state;
    logic [CH_W-1:0]     grant, last_grant, pick;
    logic                pick_vld, take, fetch;
    logic [AW-1:0]       rd_addr, fetch_ptr;
    logic [LEN_W-1:0]    fetch_rem;
    logic [DATA_W:0]     sel_word;
    logic                sk_valid, sk_last;
    logic [DATA_W-1:0]   sk_data;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign rd_adv[c] = take && (grant == CH_W'(c));
        assign pop[c]    = rd_adv[c] && out_last;

        frame_queue_chan #(
            .DEPTH(DEPTH), .DATA_W(DATA_W), .LEN_W(LEN_W),
            .AF_LEVEL(AF_LEVEL), .AF_HYST(AF_HYST)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[c]),
            .in_data  (in_data[c*DATA_W +: DATA_W]),
            .in_last  (in_last[c]),
            .in_err   (in_err[c]),
            .rd_addr  (rd_addr),
            .rd_word  (rd_word[c]),
            .rd_adv   (rd_adv[c]),
            .pop      (pop[c]),
            .has_frame(has_frame[c]),
            .head_len (head_len[c]),
            .head_ptr (head_ptr[c]),
            .pause_req(pause_req[c]),
            .drop_cnt (drop_cnt[c*CNT_W +: CNT_W]),
            .frm_cnt  (frm_cnt[c*CNT_W +: CNT_W])
        );
    end

    // Round robin: descending scan so the nearest channel after last_grant wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = N_CH; i >= 1; i--) begin
            if (has_frame[(int'(last_grant) + i) % N_CH]) begin
                pick_vld = 1'b1;
                pick     = CH_W'((int'(last_grant) + i) % N_CH);
            end
        end
    end

    assign take     = out_valid && out_ready;
    assign rd_addr  = (state == LOAD) ? head_ptr[grant] : fetch_ptr;
    assign sel_word = rd_word[grant];
    // Fetch ahead while bytes remain and the skid slot is free or draining this cycle.
    assign fetch    = (state == STREAM) && (fetch_rem != '0) && (!sk_valid || take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_chan   <= '0;
            out_len    <= '0;
            sk_valid   <= 1'b0;
            sk_last    <= 1'b0;
            sk_data    <= '0;
            fetch_ptr  <= '0;
            fetch_rem  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant <= pick;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    out_valid             <= 1'b1;
                    {out_last, out_data}  <= sel_word;
                    out_chan              <= grant;
                    out_len               <= head_len[grant];
                    fetch_ptr             <= head_ptr[grant] + ONE;
                    fetch_rem             <= head_len[grant] - LEN_W'(1);
                    sk_valid              <= 1'b0;
                    state                 <= STREAM;
                end
                STREAM: begin
                    if (fetch) begin
                        fetch_ptr <= fetch_ptr + ONE;
                        fetch_rem <= fetch_rem - LEN_W'(1);
                    end
                    if (take && out_last) begin
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        sk_valid   <= 1'b0;
                        last_grant <= grant;
                        state      <= IDLE;
                    end else if (take) begin
                        if (sk_valid) begin
                            {out_last, out_data} <= {sk_last, sk_data};
                            sk_valid             <= fetch;
                            if (fetch) {sk_last, sk_data} <= sel_word;
                        end else begin
                            {out_last, out_data} <= sel_word;
                        end
                    end else if (fetch) begin
                        sk_valid           <= 1'b1;
                        {sk_last, sk_data} <= sel_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_queue_mux.sv
// Directed bench for frame_queue_mux: latency, arbitration, error/overflow drops,
// pause hysteresis, stalls and mid-frame reset.
module tb_frame_queue_mux;

    localparam int N_CH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   in_valid, in_last, in_err;
    logic [N_CH*8-1:0] in_data;
    logic              out_valid, out_last, out_ready;
    logic [7:0]        out_data;
    logic [0:0]        out_chan;
    logic [15:0]       out_len;
    logic [N_CH-1:0]   pause_req;
    logic [N_CH*16-1:0] drop_cnt, frm_cnt;

    frame_queue_mux #(
        .N_CH(N_CH), .DATA_W(8), .DEPTH(256), .LEN_W(16), .AF_LEVEL(192), .AF_HYST(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_chan(out_chan), .out_len(out_len), .out_ready(out_ready),
        .pause_req(pause_req), .drop_cnt(drop_cnt), .frm_cnt(frm_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int stall_cnt = 0, stall_bad = 0;
    logic        hold_vld = 1'b0;
    logic [9:0]  hold = '0;
    logic [7:0]  rx_data[$];
    bit          rx_last[$];
    int          rx_chan[$];
    int          rx_len[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int c, input int base, input int i);
        return 8'(base + 16*c + i);
    endfunction

    // Accepted bytes are logged, and stalled outputs must hold until accepted.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (hold_vld && hold != {out_data, out_last, out_chan}) stall_bad <= stall_bad + 1;
            if (out_ready) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
                rx_chan.push_back(int'(out_chan));
                rx_len.push_back(int'(out_len));
                hold_vld <= 1'b0;
            end else begin
                hold_vld  <= 1'b1;
                hold      <= {out_data, out_last, out_chan};
                stall_cnt <= stall_cnt + 1;
            end
        end else begin
            hold_vld <= 1'b0;
        end
    end

    task automatic send(input int mask, input int len, input int base, input bit err);
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (mask[c]) begin
                    in_valid[c]         = 1'b1;
                    in_data[c*8 +: 8]   = pat(c, base, i);
                    in_last[c]          = (i == len - 1);
                    in_err[c]           = err && (i == len - 1);
                end
            end
            tick();
        end
        in_valid = '0;
        in_last  = '0;
        in_err   = '0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && rx_data.size() < n; k++) tick();
        chk({tag, "_cnt"}, rx_data.size(), n);
    endtask

    task automatic check_frame(input string tag, input int idx0, input int ch,
                               input int len, input int base);
        int bad_d, bad_l, bad_c, bad_n;
        bad_d = 0; bad_l = 0; bad_c = 0; bad_n = 0;
        if (rx_data.size() < idx0 + len) begin
            chk({tag, "_size"}, rx_data.size(), idx0 + len);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (rx_data[idx0+i] != pat(ch, base, i)) bad_d++;
            if (rx_last[idx0+i] != (i == len - 1)) bad_l++;
            if (rx_chan[idx0+i] != ch) bad_c++;
            if (rx_len[idx0+i] != len) bad_n++;
        end
        chk({tag, "_data_errs"}, bad_d, 0);
        chk({tag, "_last_errs"}, bad_l, 0);
        chk({tag, "_chan_errs"}, bad_c, 0);
        chk({tag, "_len_errs"},  bad_n, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"},  int'(out_last), 0);
        chk({tag, "_out_data"},  int'(out_data), 0);
        chk({tag, "_out_chan"},  int'(out_chan), 0);
        chk({tag, "_out_len"},   int'(out_len), 0);
        chk({tag, "_pause"},     int'(pause_req), 0);
        chk({tag, "_drop_cnt"},  int'(drop_cnt), 0);
        chk({tag, "_frm_cnt"},   int'(frm_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0; in_err = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk_reset("rst0");
        rst_n = 1'b1;
        tick();

        // 1: single 64-byte frame, 3-cycle latency, no bubbles
        out_ready = 1'b1;
        send(1, 64, 'h10, 0);
        chk("t1_lat0", int'(out_valid), 0);
        tick();
        chk("t1_lat1", int'(out_valid), 0);
        tick();
        chk("t1_lat2", int'(out_valid), 1);
        chk("t1_chan", int'(out_chan), 0);
        chk("t1_len",  int'(out_len), 64);
        chk("t1_first", int'(out_data), int'(pat(0, 'h10, 0)));
        repeat (64) tick();
        chk("t1_nobubble", rx_data.size(), 64);
        chk("t1_idle", int'(out_valid), 0);
        check_frame("t1", 0, 0, 64, 'h10);
        chk("t1_frm0", int'(frm_cnt[15:0]), 1);

        // 2: simultaneous commits, last_grant=0 so ch1 goes first
        rx_data.delete(); rx_last.delete(); rx_chan.delete(); rx_len.delete();
        send(3, 60, 'h20, 0);
        wait_rx("t2", 120, 300);
        check_frame("t2_ch1", 0, 1, 60, 'h20);
        check_frame("t2_ch0", 60, 0, 60, 'h20);
        chk("t2_frm0", int'(frm_cnt[15:0]), 2);
        chk("t2_frm1", int'(frm_cnt[31:16]), 1);

        // 3: errored frame discarded, following good frame delivered
        rx_data.delete(); rx_last.delete(); rx_chan.delete(); rx_len.delete();
        send(2, 100, 'h40, 1);
        send(2, 70, 'h50, 0);
        wait_rx("t3", 70, 200);
        repeat (5) tick();
        chk("t3_only", rx_data.size(), 70);
        check_frame("t3", 0, 1, 70, 'h50);
        chk("t3_drop1", int'(drop_cnt[31:16]), 1);
        chk("t3_frm1",  int'(frm_cnt[31:16]), 2);

        // 4: overflow with output stalled behind a committed 10-byte frame
        rx_data.delete(); rx_last.delete(); rx_chan.delete(); rx_len.delete();
        out_ready = 1'b0;
        send(1, 10, 'h80, 0);
        repeat (4) tick();
        for (int i = 0; i < 300; i++) begin
            in_valid[0] = 1'b1;
            in_data[7:0] = pat(0, 'h90, i);
            in_last[0] = (i == 299);
            tick();
            if (i == 181) chk("t4_pause_below", int'(pause_req[0]), 0);
            if (i == 182) chk("t4_pause_at",    int'(pause_req[0]), 1);
            if (i == 245) chk("t4_pause_full",  int'(pause_req[0]), 1);
            if (i == 246) chk("t4_pause_clear", int'(pause_req[0]), 0);
        end
        in_valid = '0; in_last = '0;
        chk("t4_drop0", int'(drop_cnt[15:0]), 1);
        chk("t4_frm0",  int'(frm_cnt[15:0]), 3);
        chk("t4_pause_end", int'(pause_req[0]), 0);
        out_ready = 1'b1;
        wait_rx("t4", 10, 50);
        repeat (6) tick();
        chk("t4_only", rx_data.size(), 10);
        check_frame("t4", 0, 0, 10, 'h80);

        // 5: out_ready toggling every cycle
        rx_data.delete(); rx_last.delete(); rx_chan.delete(); rx_len.delete();
        out_ready = 1'b0;
        send(1, 64, 'h05, 0);
        for (int k = 0; k < 400 && rx_data.size() < 64; k++) begin
            out_ready = ~out_ready;
            tick();
        end
        chk("t5_cnt", rx_data.size(), 64);
        check_frame("t5", 0, 0, 64, 'h05);
        chk("t5_frm0", int'(frm_cnt[15:0]), 4);
        chk("t5_stalls_seen", int'(stall_cnt > 0), 1);
        chk("stall_stable", stall_bad, 0);

        // 6: reset mid-frame on both read and write sides
        out_ready = 1'b0;
        send(1, 40, 'hC0, 0);
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid[1] = 1'b1;
            in_data[15:8] = pat(1, 'h70, i);
            in_last[1] = 1'b0;
            tick();
        end
        chk("t6_pre_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("t6_rst");
        in_valid = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rx_data.delete(); rx_last.delete(); rx_chan.delete(); rx_len.delete();
        out_ready = 1'b1;
        send(2, 16, 'h30, 0);
        wait_rx("t6", 16, 50);
        repeat (6) tick();
        chk("t6_only", rx_data.size(), 16);
        check_frame("t6", 0, 1, 16, 'h30);
        chk("t6_frm1",  int'(frm_cnt[31:16]), 1);
        chk("t6_frm0",  int'(frm_cnt[15:0]), 0);
        chk("t6_drop",  int'(drop_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_queue_mux.md
Name: frame_queue_mux

Overview:
- N-channel store-and-forward frame buffer that succeeds the single-channel byte FIFO and separate frame-length FIFO used between MAC RX and TX control.
- Each channel accepts bytes with a last/error marker and commits only complete, error-free frames. Frames that error or overflow are discarded.
- A round-robin arbiter streams whole committed frames onto one shared TX byte stream with a valid/ready handshake.
- Per-channel pause requests drive the pause-frame controller.

Parameters:
- N_CH, 2, number of input channels (1..8)
- DATA_W, 8, byte lane width
- DEPTH, 2048, entries per channel; power of two
- LEN_W, 16, frame length counter width
- AF_LEVEL, DEPTH-256, used-entry count at or above which pause_req asserts
- AF_HYST, 128, pause_req deasserts when used < AF_LEVEL-AF_HYST

Ports:
- clk  in  1  single clock for both write and read sides
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  N_CH  per-channel byte strobe
- in_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- in_last  in  N_CH  final byte of frame, qualified by in_valid
- in_err  in  N_CH  frame bad (FCS/PHY error); sampled with in_last
- out_valid  out  1  out_data holds a valid byte
- out_data  out  DATA_W  output byte
- out_last  out  1  final byte of the current output frame
- out_chan  out  $clog2(N_CH) (min 1)  source channel of the current frame
- out_len  out  LEN_W  byte length of the current frame; valid while out_valid
- out_ready  in  1  downstream accepts the byte
- pause_req  out  N_CH  channel near full
- drop_cnt  out  N_CH*16  saturating per-channel dropped-frame counters
- frm_cnt  out  N_CH*16  wrapping per-channel committed-frame counters

Behaviour:
- Reset (asynchronous, rst_n=0): all pointers, counters and the arbiter state clear to 0.
  - Outputs at reset: out_valid=0, out_last=0, out_data=0, out_chan=0, out_len=0, pause_req=0, drop_cnt=0, frm_cnt=0.
  - A partially written frame at reset is discarded. A partially read frame is abandoned.
- Per-channel write side:
  - Channel c keeps wr_ptr (speculative), commit_ptr, rd_ptr, and a length counter.
  - Memory word is {last, data}.
  - Each in_valid writes at wr_ptr and increments wr_ptr and len; pointers wrap modulo DEPTH.
- Commit, on in_valid & in_last & !in_err & no overflow in this frame:
  - commit_ptr <= wr_ptr+1.
  - Push len+1 into the channel length queue (depth 16).
  - frm_cnt[c]++; len clears.
- Drop, on in_last & in_err, or overflow:
  - wr_ptr <= commit_ptr; drop_cnt[c]++ (saturates at 16'hFFFF).
  - Overflow means a write arrives when wr_ptr+1 == rd_ptr, or the length queue is full at commit. The channel then ignores bytes until in_last, and counts one drop at in_last.
- Zero-length frames do not exist: in_last always accompanies a data byte.
- Availability: a channel has a frame when its length queue is non-empty. A committed frame becomes visible to the arbiter the cycle after commit.
- Arbiter FSM, states IDLE, LOAD, STREAM:
  - IDLE: choose the lowest channel index greater than last_grant (wrapping) that has a frame; go to LOAD. With no request, stay in IDLE.
  - LOAD: issue memory read at rd_ptr; latch out_len from the head of the length queue and out_chan; go to STREAM.
  - STREAM: out_valid=1. The next byte is prefetched into a 1-entry skid register so that out_ready held high gives 1 byte/cycle with no bubbles. On out_valid & out_ready: rd_ptr++. If out_last: pop the length queue, record last_grant, and go to IDLE.
- Latency: from the commit cycle to out_valid is 3 cycles with out_ready=1 and the arbiter idle.
- Handshake: out_data, out_last and out_chan stay stable while out_valid & !out_ready. out_valid never drops mid-frame except after out_last is accepted.
- Frames are never interleaved; the grant is held for the entire frame.
- Same-channel read and write in the same cycle is legal. Used-count = wr_ptr-rd_ptr modulo DEPTH. Freed space is visible to the write side the next cycle.
- pause_req[c] uses the AF_LEVEL/AF_HYST hysteresis and is registered, asserting 1 cycle after the threshold is crossed.

Decomposition:
- Package frame_queue_pkg holds:
  - typedef arb_state_t {IDLE, LOAD, STREAM}
  - localparams PTR_W=$clog2(DEPTH), LENQ_DEPTH=16, CNT_W=16
- Sub-module frame_queue_chan is generated N_CH times. It contains the memory, pointers, length queue, commit/drop logic, pause hysteresis and counters, and exposes has_frame, head_len, a read-port and a pop.
- The top module holds the arbiter FSM, the skid register and the output mux.

Test Plan:
1. N_CH=2, ch0 sends a 64-byte good frame, out_ready=1 -> out_valid rises 3 cycles after in_last; 64 consecutive bytes match; out_last on byte 64; out_len=64; out_chan=0; frm_cnt[0]=1.
2. ch0 and ch1 each commit a 60-byte frame in the same cycle, last_grant=0 -> ch1 streams first, then ch0, with no interleaving.
3. ch1 sends 100 bytes ending with in_err=1, followed by a good 70-byte frame -> only the 70-byte frame appears; drop_cnt[1]=1; used-count returns to 70.
4. DEPTH=256, out_ready=0, ch0 writes 300-byte frame -> frame dropped at in_last; drop_cnt[0]=1; previously committed data intact; pause_req[0] asserted at used=AF_LEVEL.
5. out_ready toggled 1/0 every cycle during a 64-byte frame -> all 64 bytes delivered in order; out_data stable during every stall.
6. rst_n pulsed low mid-frame on both sides -> all outputs 0 asynchronously; next good frame after release is delivered correctly.
